// File: rtl/tff_updown_counter_pkg.sv
// Shared constants for the toggle-cell up/down counter.
package tff_cnt_pkg;
  localparam int   W_DEF   = 4;
  localparam int   MOD_DEF = 10;
  localparam logic DIR_UP  = 1'b1;
  localparam logic DIR_DN  = 1'b0;
endpackage

// File: rtl/tff_updown_counter_if.sv
// Control/status bundle of the toggle-cell counter; master drives controls, slave returns count and flags.
interface tff_updown_counter_if #(parameter int W = 4);
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] din;
  logic         clr_ovf;
  logic [W-1:0] q;
  logic         tc;
  logic         ovf;

  modport master (output en, up, load, din, clr_ovf, input q, tc, ovf);
  modport slave  (input en, up, load, din, clr_ovf, output q, tc, ovf);
endinterface

// File: rtl/tff_updown_counter_t_cell.sv
// Single T flip-flop bit cell: toggles on t, synchronous active-low clear.
module t_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q,
  output logic qbar
);
  logic q_q;

  always_ff @(posedge clk) begin
    if (!rst)   q_q <= 1'b0;
    else if (t) q_q <= ~q_q;
  end

  assign q    = q_q;
  assign qbar = ~q_q;
endmodule

// File: rtl/tff_updown_counter.sv
// Up/down counter built from t_cell bits: generates per-bit toggle enables, tc pulse and sticky ovf.
// Optional macro TFF_CNT_MODULO_EN wraps at MOD instead of 2^W.
module tff_updown_counter
  import tff_cnt_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int MOD = MOD_DEF
) (
  input logic                  clk,
  input logic                  rst,
  tff_updown_counter_if.slave  bus
);
  logic [W-1:0] q_w, qbar_w, t_vec;
  logic [W-1:0] up_t, dn_t, up_tv, dn_tv, ld_val;
  logic         wrap_up, wrap_dn, wrap;
  logic         tc_d, tc_q, ovf_d, ovf_q;

  // Ripple-style enables: bit i toggles when every lower bit is 1 (up) or 0 (down).
  assign up_t[0] = 1'b1;
  assign dn_t[0] = 1'b1;
  for (genvar i = 1; i < W; i++) begin : g_ten
    assign up_t[i] = &q_w[i-1:0];
    assign dn_t[i] = &qbar_w[i-1:0];
  end

`ifdef TFF_CNT_MODULO_EN
  localparam logic [W-1:0] TOP = W'(MOD - 1);
  assign wrap_up = (q_w == TOP);
  assign wrap_dn = (q_w == '0);
  // Wrap points jump straight to the target value, so toggle q^target there.
  assign up_tv   = wrap_up ? q_w : up_t;
  assign dn_tv   = wrap_dn ? (q_w ^ TOP) : dn_t;
  assign ld_val  = (32'(bus.din) >= MOD) ? TOP : bus.din;
`else
  assign wrap_up = &q_w;
  assign wrap_dn = ~|q_w;
  assign up_tv   = up_t;
  assign dn_tv   = dn_t;
  assign ld_val  = bus.din;
`endif

  always_comb begin
    t_vec = '0;
    wrap  = 1'b0;
    if (bus.load) begin
      t_vec = q_w ^ ld_val;
    end else if (bus.en) begin
      if (bus.up == DIR_UP) begin
        t_vec = up_tv;
        wrap  = wrap_up;
      end else begin
        t_vec = dn_tv;
        wrap  = wrap_dn;
      end
    end
  end

  for (genvar i = 0; i < W; i++) begin : g_cell
    t_cell u_cell (
      .clk  (clk),
      .rst  (rst),
      .t    (t_vec[i]),
      .q    (q_w[i]),
      .qbar (qbar_w[i])
    );
  end

  // A wrap sets ovf even when clr_ovf is asserted on the same edge.
  assign tc_d  = wrap;
  assign ovf_d = bus.load ? ovf_q : (wrap | (ovf_q & ~bus.clr_ovf));

  always_ff @(posedge clk) begin
    if (!rst) begin
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.q   = q_w;
  assign bus.tc  = tc_q;
  assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_tff_updown_counter.sv
// Directed + randomized check of tff_updown_counter against an arithmetic reference model.
module tb_tff_updown_counter;
  localparam int W   = 4;
  localparam int MOD = 10;
`ifdef TFF_CNT_MODULO_EN
  localparam int RANGE = MOD;
`else
  localparam int RANGE = 1 << W;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   m_q = 0, m_tc = 0, m_ovf = 0;

  tff_updown_counter_if #(.W(W)) bus ();
  tff_updown_counter #(.W(W), .MOD(MOD)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: plain modular arithmetic over RANGE.
  task automatic model(input bit r, input bit ld, input bit e, input bit u, input int d, input bit c);
    int dv;
    bit wr;
    dv = d % (1 << W);
    if (!r) begin
      m_q = 0; m_tc = 0; m_ovf = 0;
    end else if (ld) begin
      m_q  = (dv >= RANGE) ? RANGE - 1 : dv;
      m_tc = 0;
    end else if (e) begin
      wr    = u ? (m_q == RANGE - 1) : (m_q == 0);
      m_q   = u ? (m_q + 1) % RANGE : (m_q + RANGE - 1) % RANGE;
      m_tc  = wr;
      m_ovf = (wr || (m_ovf && !c)) ? 1 : 0;
    end else begin
      m_tc  = 0;
      m_ovf = (m_ovf && !c) ? 1 : 0;
    end
  endtask

  task automatic step(input string tag, input bit r, input bit ld, input bit e, input bit u,
                      input int d, input bit c);
    rst = r; bus.load = ld; bus.en = e; bus.up = u; bus.din = W'(d); bus.clr_ovf = c;
    @(posedge clk);
    model(r, ld, e, u, d, c);
    #1;
    chk({tag, ".q"},   32'(bus.q),   32'(m_q));
    chk({tag, ".tc"},  32'(bus.tc),  32'(m_tc));
    chk({tag, ".ovf"}, 32'(bus.ovf), 32'(m_ovf));
  endtask

  initial begin
    bus.en = 0; bus.up = 1; bus.load = 0; bus.din = '0; bus.clr_ovf = 0;

    // Reset dominates load and count
    step("rst0", 0, 1, 1, 1, 9, 0);
    step("rst1", 0, 1, 1, 1, 9, 0);
    chk("rst.q_const", 32'(bus.q), 0);
    step("rst_up", 1, 0, 1, 1, 0, 0);
    chk("rst_up.q_const", 32'(bus.q), 1);

`ifndef TFF_CNT_MODULO_EN
    step("ld14", 1, 1, 0, 0, 14, 0);
    step("up15", 1, 0, 1, 1, 0, 0);
    chk("up15.q_const", 32'(bus.q), 15);
    step("wrapup", 1, 0, 1, 1, 0, 0);
    chk("wrapup.tc_const", 32'(bus.tc), 1);
    chk("wrapup.ovf_const", 32'(bus.ovf), 1);
    step("postwrap", 1, 0, 1, 1, 0, 0);
    chk("postwrap.tc_const", 32'(bus.tc), 0);
    step("ld0", 1, 1, 0, 0, 0, 0);
    step("dnwrap_clr", 1, 0, 1, 0, 0, 1);
    chk("dnwrap_clr.q_const", 32'(bus.q), 15);
    chk("dnwrap_clr.ovf_const", 32'(bus.ovf), 1);
    step("clr_hold", 1, 0, 0, 0, 0, 1);
    chk("clr_hold.ovf_const", 32'(bus.ovf), 0);
`else
    step("mld0", 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step("mod_up", 1, 0, 1, 1, 0, 0);
    chk("mod_up.q_const", 32'(bus.q), 0);
    chk("mod_up.tc_const", 32'(bus.tc), 1);
    step("mod_dn", 1, 0, 1, 0, 0, 0);
    chk("mod_dn.q_const", 32'(bus.q), 9);
    step("mod_ld12", 1, 1, 0, 0, 12, 0);
    chk("mod_ld12.q_const", 32'(bus.q), 9);
`endif

    // Load beats count, then reset beats load
    step("prio_ld", 1, 1, 1, 1, 5, 0);
    chk("prio_ld.q_const", 32'(bus.q), 5);
    step("prio_rst", 0, 1, 0, 0, 5, 0);
    chk("prio_rst.q_const", 32'(bus.q), 0);

    // Direction reversal
    step("rev_ld7", 1, 1, 0, 0, 7, 0);
    step("rev_u", 1, 0, 1, 1, 0, 0);
    step("rev_d", 1, 0, 1, 0, 0, 0);
    step("rev_d", 1, 0, 1, 0, 0, 0);
    step("rev_u", 1, 0, 1, 1, 0, 0);
    chk("rev.q_const", 32'(bus.q), 7);

    for (int n = 0; n < 400; n++) begin
      step("rnd",
           ($urandom_range(0, 49) != 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 9) < 7),
           1'($urandom),
           int'($urandom_range(0, (1 << W) - 1)),
           ($urandom_range(0, 6) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
